// File: rtl/icon_opd_forwarder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icon_opd_forwarder_pkg
// Description : Shared types and instance defaults for the operand forwarder.
// Revision    : 1.0 - initial release
// ============================================================================
package icon_opd_forwarder_pkg;

  localparam int ICON_FWD_NUM_EU        = 4;
  localparam int ICON_FWD_REQ_IDX_BITS  = 2;
  localparam int ICON_FWD_MAX_RETRY     = 7;

  typedef struct packed {
    logic [2:0] euidx;
    logic [3:0] uid;
    logic       spec;
  } type_exec_unit_addr;

  typedef logic [31:0] type_exec_unit_data;

  typedef struct packed {
    type_exec_unit_addr addr;
    logic               valid;
    type_exec_unit_data data;
  } type_icon_tx_channel;

  typedef struct packed {
    logic success;
  } type_icon_rx_channel;

  typedef enum logic [1:0] {
    FWD_IDLE  = 2'd0,
    FWD_READ  = 2'd1,
    FWD_WRITE = 2'd2
  } type_icon_fwd_state;

endpackage
`default_nettype wire

// File: rtl/icon_opd_forwarder_if.sv
`default_nettype none
// ============================================================================
// Module      : icon_opd_forwarder_if
// Description : Request, EU read-port and operand write-channel bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface icon_opd_forwarder_if
  import icon_opd_forwarder_pkg::*;
#(
  parameter int NUM_EU = ICON_FWD_NUM_EU
);
  type_exec_unit_addr                    req_addr_i;
  logic                                  req_valid_i;
  logic                                  req_ready_o;
  type_exec_unit_addr                    icon_raddr_o;
  logic               [NUM_EU-1:0]       icon_rvalid_o;
  type_exec_unit_data [NUM_EU-1:0]       icon_rdata_i;
  logic               [NUM_EU-1:0]       icon_rsuccess_i;
  type_icon_tx_channel                   icon_w_o;
  type_icon_rx_channel                   icon_w_rx_i;
  logic                                  busy_o;
  logic                                  done_o;
  logic                                  err_o;

  modport master (
    input  req_addr_i, req_valid_i, icon_rdata_i, icon_rsuccess_i, icon_w_rx_i,
    output req_ready_o, icon_raddr_o, icon_rvalid_o, icon_w_o, busy_o, done_o, err_o
  );

  modport slave (
    output req_addr_i, req_valid_i, icon_rdata_i, icon_rsuccess_i, icon_w_rx_i,
    input  req_ready_o, icon_raddr_o, icon_rvalid_o, icon_w_o, busy_o, done_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/icon_opd_forwarder_reqfifo.sv
`default_nettype none
// ============================================================================
// Module      : icon_opd_forwarder_reqfifo
// Description : Synchronous request FIFO of operand addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module icon_opd_forwarder_reqfifo
  import icon_opd_forwarder_pkg::*;
#(
  parameter int IDX_BITS = ICON_FWD_REQ_IDX_BITS
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               i_push,
  input  type_exec_unit_addr      i_push_data,
  input  wire logic               i_pop,
  output type_exec_unit_addr      o_head,
  output logic                    o_full,
  output logic                    o_empty
);
  localparam int DEPTH = 1 << IDX_BITS;

  type_exec_unit_addr  r_mem [DEPTH];
  logic [IDX_BITS:0]   r_wr_ptr;
  logic [IDX_BITS:0]   r_rd_ptr;
  logic                w_wr_en;
  logic                w_rd_en;

  // Extra MSB on each pointer separates full from empty when indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[IDX_BITS] != r_rd_ptr[IDX_BITS]) &&
                   (r_wr_ptr[IDX_BITS-1:0] == r_rd_ptr[IDX_BITS-1:0]);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[IDX_BITS-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[IDX_BITS-1:0]] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/icon_opd_forwarder.sv
`default_nettype none
// ============================================================================
// Module      : icon_opd_forwarder
// Description : Reads queued foreign operands from source EUs and writes them
//               into one destination operand channel.
// Revision    : 1.0 - initial release
// ============================================================================
module icon_opd_forwarder
  import icon_opd_forwarder_pkg::*;
#(
  parameter int NUM_EU       = ICON_FWD_NUM_EU,
  parameter int REQ_IDX_BITS = ICON_FWD_REQ_IDX_BITS,
  parameter int MAX_RETRY    = ICON_FWD_MAX_RETRY
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  icon_opd_forwarder_if.master bus
);
  localparam int CNT_W = $clog2(MAX_RETRY + 1);
  localparam int SEL_W = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
  localparam logic [CNT_W-1:0] C_LAST_MISS = CNT_W'(MAX_RETRY - 1);

  type_icon_fwd_state   r_state;
  type_icon_fwd_state   w_state_nxt;
  type_exec_unit_addr   r_cur_addr;
  type_exec_unit_data   r_data;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done;
  logic                 r_err;

  type_exec_unit_addr   w_head;
  type_exec_unit_addr   w_push_addr;
  logic                 w_push, w_pop, w_full, w_empty;
  logic                 w_src_ok, w_hit, w_rotate, w_ready;
  logic [SEL_W-1:0]     w_sel;
  logic [NUM_EU-1:0]    w_rvalid;
  type_exec_unit_addr   w_raddr;
  type_icon_tx_channel  w_tx;

  assign w_src_ok = (32'(w_head.euidx) < NUM_EU);
  assign w_sel    = r_cur_addr.euidx[SEL_W-1:0];
  assign w_hit    = bus.icon_rsuccess_i[w_sel];

  // A rotate is held off while the FIFO is full; the counter then stays at its
  // last value so the very next miss with free space rotates.
  assign w_rotate = (r_state == FWD_READ) && !w_hit && (r_cnt == C_LAST_MISS) && !w_full;
  assign w_ready     = !w_full && !w_rotate;
  assign w_push      = w_rotate || (bus.req_valid_i && w_ready);
  assign w_push_addr = w_rotate ? r_cur_addr : bus.req_addr_i;

  icon_opd_forwarder_reqfifo #(
    .IDX_BITS (REQ_IDX_BITS)
  ) u_reqfifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_addr),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rvalid    = '0;
    w_raddr     = '0;
    w_tx        = '0;
    case (r_state)
      FWD_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_src_ok) w_state_nxt = FWD_READ;
        end
      end
      FWD_READ: begin
        w_raddr  = r_cur_addr;
        w_rvalid = NUM_EU'(1) << w_sel;
        if (w_hit)         w_state_nxt = FWD_WRITE;
        else if (w_rotate) w_state_nxt = FWD_IDLE;
      end
      FWD_WRITE: begin
        w_tx.valid = 1'b1;
        w_tx.addr  = r_cur_addr;
        w_tx.data  = r_data;
        if (bus.icon_w_rx_i.success) w_state_nxt = FWD_IDLE;
      end
      default: w_state_nxt = FWD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FWD_IDLE;
      r_cur_addr <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == FWD_WRITE) && bus.icon_w_rx_i.success;
      r_err   <= (r_state == FWD_IDLE) && !w_empty && !w_src_ok;
      if ((r_state == FWD_IDLE) && !w_empty && w_src_ok) begin
        r_cur_addr <= w_head;
        r_cnt      <= '0;
      end
      if (r_state == FWD_READ) begin
        if (w_hit)                    r_data <= bus.icon_rdata_i[w_sel];
        else if (r_cnt != C_LAST_MISS) r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready_o   = w_ready;
  assign bus.icon_raddr_o  = w_raddr;
  assign bus.icon_rvalid_o = w_rvalid;
  assign bus.icon_w_o      = w_tx;
  assign bus.busy_o        = (r_state != FWD_IDLE) || !w_empty;
  assign bus.done_o        = r_done;
  assign bus.err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_icon_opd_forwarder.sv
`default_nettype none
// ============================================================================
// Module      : tb_icon_opd_forwarder
// Description : Self-checking bench for the operand forwarder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icon_opd_forwarder;
  import icon_opd_forwarder_pkg::*;

  localparam int NUM_EU    = 4;
  localparam int MAX_RETRY = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  icon_opd_forwarder_if #(.NUM_EU(NUM_EU)) bus ();

  icon_opd_forwarder #(
    .NUM_EU       (NUM_EU),
    .REQ_IDX_BITS (2),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [NUM_EU-1:0] dir_mask = '0;
  logic [NUM_EU-1:0] rnd_mask = '0;
  logic              dir_wsucc = 1'b0;
  logic              rnd_wsucc = 1'b0;
  bit                rand_mode = 1'b0;
  bit                use_fixed = 1'b0;
  logic [31:0]       fixed_data = '0;

  function automatic logic [31:0] data_of(type_exec_unit_addr a);
    return {4{a}} ^ 32'h1357_9BDF;
  endfunction

  function automatic type_exec_unit_addr mk(int e, int u, int s);
    type_exec_unit_addr a;
    a.euidx = 3'(e);
    a.uid   = 4'(u);
    a.spec  = 1'(s);
    return a;
  endfunction

  assign bus.icon_rsuccess_i     = rand_mode ? rnd_mask  : dir_mask;
  assign bus.icon_w_rx_i.success = rand_mode ? rnd_wsucc : dir_wsucc;

  for (genvar e = 0; e < NUM_EU; e++) begin : g_eu
    assign bus.icon_rdata_i[e] = use_fixed ? fixed_data : data_of(bus.icon_raddr_o);
  end

  always @(posedge clk) begin
    #1;
    rnd_mask  = NUM_EU'($urandom);
    rnd_wsucc = ($urandom_range(0, 2) != 0);
  end

  // Observation log built at the falling edge.
  int                 strobes [NUM_EU];
  type_exec_unit_addr wlog_addr [$];
  logic [31:0]        wlog_data [$];
  int                 n_done = 0;
  int                 n_err  = 0;
  int                 prot_viol = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if ((bus.icon_rvalid_o != '0) && bus.icon_w_o.valid) prot_viol++;
      if (!$onehot0(bus.icon_rvalid_o)) prot_viol++;
      for (int e = 0; e < NUM_EU; e++) if (bus.icon_rvalid_o[e]) strobes[e]++;
      if (bus.icon_w_o.valid && bus.icon_w_rx_i.success) begin
        wlog_addr.push_back(bus.icon_w_o.addr);
        wlog_data.push_back(bus.icon_w_o.data);
      end
      if (bus.done_o) n_done++;
      if (bus.err_o)  n_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (wlog_addr.size() >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    #3;
    n_tests++; if (bus.icon_rvalid_o !== '0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.icon_rvalid_o); end
    n_tests++; if (bus.icon_w_o !== '0) begin n_fail++; $display("FAIL reset_w: got %h want 0", bus.icon_w_o); end
    n_tests++; if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b err=%b want 0", bus.done_o, bus.err_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_tests++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    type_exec_unit_addr a;
    a = mk(1, 5, 0);
    use_fixed = 1'b1; fixed_data = 32'h0000_A5A5;
    dir_mask = 4'b0010; dir_wsucc = 1'b1;
    bus.req_valid_i = 1'b1; bus.req_addr_i = a;          // c0
    tick(); bus.req_valid_i = 1'b0; #3;                  // c1
    n_tests++; if (bus.icon_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL basic_c1_rvalid: got %b want 0000", bus.icon_rvalid_o); end
    tick(); #3;                                          // c2
    n_tests++; if (bus.icon_rvalid_o !== 4'b0010 || bus.icon_raddr_o !== a) begin n_fail++; $display("FAIL basic_c2_read: got rvalid=%b raddr=%h want 0010 %h", bus.icon_rvalid_o, bus.icon_raddr_o, a); end
    tick(); #3;                                          // c3
    n_tests++; if (bus.icon_w_o.valid !== 1'b1 || bus.icon_w_o.data !== 32'h0000_A5A5 || bus.icon_w_o.addr !== a) begin n_fail++; $display("FAIL basic_c3_write: got v=%b d=%h a=%h want 1 0000a5a5 %h", bus.icon_w_o.valid, bus.icon_w_o.data, bus.icon_w_o.addr, a); end
    n_tests++; if (bus.icon_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL basic_c3_rvalid: got %b want 0000", bus.icon_rvalid_o); end
    tick(); #3;                                          // c4
    n_tests++; if (bus.done_o !== 1'b1 || bus.icon_w_o.valid !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_c4_done: got done=%b wv=%b busy=%b want 1 0 0", bus.done_o, bus.icon_w_o.valid, bus.busy_o); end
    tick(); #3;
    n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL basic_c5_done: got %b want 0", bus.done_o); end
    use_fixed = 1'b0;
    tick();
  endtask

  task automatic test_read_retry();
    type_exec_unit_addr a;
    int base, wbase;
    a = mk(2, 3, 0);
    wbase = wlog_addr.size();
    dir_mask = '0; dir_wsucc = 1'b1; base = strobes[2];
    bus.req_valid_i = 1'b1; bus.req_addr_i = a;          // c0
    tick(); bus.req_valid_i = 1'b0;                      // c1
    tick(); tick(); tick();                              // c2..c4 misses
    tick(); dir_mask = 4'b0100;                          // c5 hit
    tick(); #3;                                          // c6
    n_tests++; if (bus.icon_w_o.valid !== 1'b1 || bus.icon_w_o.data !== data_of(a)) begin n_fail++; $display("FAIL retry_write: got v=%b d=%h want 1 %h", bus.icon_w_o.valid, bus.icon_w_o.data, data_of(a)); end
    dir_mask = '0;
    tick(); #3;                                          // c7
    n_tests++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL retry_done: got %b want 1", bus.done_o); end
    n_tests++; if (strobes[2] - base !== 4) begin n_fail++; $display("FAIL retry_strobes: got %0d want 4", strobes[2] - base); end
    // Second request: six misses must not rotate if the counter restarted.
    a = mk(2, 4, 0);
    tick(); base = strobes[2];
    bus.req_valid_i = 1'b1; bus.req_addr_i = a;          // c0
    tick(); bus.req_valid_i = 1'b0;                      // c1
    repeat (7) tick();                                   // c8
    dir_mask = 4'b0100;
    tick(); tick(); #3;                                  // c10
    n_tests++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL retry_cnt_clear_done: got %b want 1", bus.done_o); end
    n_tests++; if (strobes[2] - base !== 7) begin n_fail++; $display("FAIL retry_cnt_clear_strobes: got %0d want 7", strobes[2] - base); end
    n_tests++; if (wlog_addr.size() - wbase !== 2) begin n_fail++; $display("FAIL retry_writes: got %0d want 2", wlog_addr.size() - wbase); end
    dir_mask = '0;
    tick();
  endtask

  task automatic test_rotate();
    type_exec_unit_addr a, b;
    int wbase, base0;
    bit ok;
    a = mk(0, 1, 0); b = mk(3, 2, 0);
    wbase = wlog_addr.size(); base0 = strobes[0];
    dir_mask = 4'b1000; dir_wsucc = 1'b1;
    bus.req_valid_i = 1'b1; bus.req_addr_i = a;          // c0
    tick(); bus.req_addr_i = b;                          // c1
    tick(); bus.req_valid_i = 1'b0;                      // c2
    repeat (5) tick(); #3;                               // c7
    n_tests++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rotate_ready_before: got %b want 1", bus.req_ready_o); end
    tick(); #3;                                          // c8
    n_tests++; if (bus.req_ready_o !== 1'b0 || bus.icon_rvalid_o !== 4'b0001) begin n_fail++; $display("FAIL rotate_cycle: got ready=%b rvalid=%b want 0 0001", bus.req_ready_o, bus.icon_rvalid_o); end
    tick(); #3;                                          // c9
    n_tests++; if (strobes[0] - base0 !== MAX_RETRY || bus.icon_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL rotate_misses: got %0d rvalid=%b want %0d 0000", strobes[0] - base0, bus.icon_rvalid_o, MAX_RETRY); end
    tick(); #3;                                          // c10
    n_tests++; if (bus.icon_rvalid_o !== 4'b1000) begin n_fail++; $display("FAIL rotate_b_read: got %b want 1000", bus.icon_rvalid_o); end
    tick(); tick(); #3;                                  // c12
    n_tests++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL rotate_b_done: got %b want 1", bus.done_o); end
    dir_mask = 4'b1001;
    wait_writes(wbase + 2, 40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rotate_drain: got %0d writes want 2", wlog_addr.size() - wbase); end
    if (ok) begin
      n_tests++; if (wlog_addr[wbase] !== b || wlog_addr[wbase+1] !== a) begin n_fail++; $display("FAIL rotate_order: got %h,%h want %h,%h", wlog_addr[wbase], wlog_addr[wbase+1], b, a); end
    end
    dir_mask = '0;
    tick(); tick();
  endtask

  task automatic test_fifo_full();
    int wbase;
    bit ok;
    wbase = wlog_addr.size();
    dir_mask = '0; dir_wsucc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid_i = 1'b1; bus.req_addr_i = mk(1, 8 + i, 0);
      tick();
    end
    bus.req_addr_i = mk(1, 13, 0); #3;                   // c5, FIFO full
    n_tests++; if (bus.req_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL full_ready: got ready=%b busy=%b want 0 1", bus.req_ready_o, bus.busy_o); end
    tick(); bus.req_valid_i = 1'b0; dir_mask = 4'b0010;
    wait_writes(wbase + 5, 80, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL full_drain: got %0d writes want 5", wlog_addr.size() - wbase); end
    repeat (10) tick();
    n_tests++; if (wlog_addr.size() - wbase !== 5) begin n_fail++; $display("FAIL full_ignored_push: got %0d writes want 5", wlog_addr.size() - wbase); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (wlog_addr[wbase+i] !== mk(1, 8 + i, 0) || wlog_data[wbase+i] !== data_of(mk(1, 8 + i, 0))) begin
          n_fail++; $display("FAIL full_order[%0d]: got %h/%h want %h/%h", i, wlog_addr[wbase+i], wlog_data[wbase+i], mk(1, 8 + i, 0), data_of(mk(1, 8 + i, 0)));
        end
      end
    end
    dir_mask = '0;
  endtask

  task automatic test_write_backpressure();
    type_exec_unit_addr a, b;
    int wbase, dbase;
    bit ok;
    a = mk(3, 7, 1); b = mk(1, 2, 0);
    wbase = wlog_addr.size(); dbase = n_done;
    dir_mask = 4'b1111; dir_wsucc = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_addr_i = a;          // c0
    tick(); bus.req_valid_i = 1'b0;                      // c1
    tick(); tick();                                      // c3
    bus.req_valid_i = 1'b1; bus.req_addr_i = b;
    for (int k = 0; k < 10; k++) begin
      #3;
      n_tests++; if (bus.icon_w_o.valid !== 1'b1 || bus.icon_w_o.addr !== a || bus.icon_w_o.data !== data_of(a)) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b a=%h d=%h want 1 %h %h", k, bus.icon_w_o.valid, bus.icon_w_o.addr, bus.icon_w_o.data, a, data_of(a)); end
      n_tests++; if (bus.icon_rvalid_o !== 4'b0000 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL bp_quiet[%0d]: got rvalid=%b done=%b want 0000 0", k, bus.icon_rvalid_o, bus.done_o); end
      tick(); bus.req_valid_i = 1'b0;
    end
    dir_wsucc = 1'b1;
    tick(); #3;
    n_tests++; if (bus.done_o !== 1'b1 || n_done !== dbase) begin n_fail++; $display("FAIL bp_done: got done=%b earlier=%0d want 1 0", bus.done_o, n_done - dbase); end
    wait_writes(wbase + 2, 30, ok);
    n_tests++; if (!ok || wlog_addr[wbase] !== a || wlog_addr[wbase+1] !== b) begin n_fail++; $display("FAIL bp_order: got %0d writes want %h then %h", wlog_addr.size() - wbase, a, b); end
    dir_mask = '0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_write_err();
    int wbase, ebase, sbase;
    dir_mask = 4'b1111; dir_wsucc = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_addr_i = mk(2, 1, 0); // c0
    tick(); bus.req_addr_i = mk(0, 3, 0);                 // c1
    tick(); bus.req_addr_i = mk(1, 4, 0);                 // c2
    tick(); bus.req_valid_i = 1'b0;                       // c3, WRITE
    #1; reset_n = 1'b0; #1;
    n_tests++; if (bus.icon_w_o !== '0 || bus.icon_rvalid_o !== '0) begin n_fail++; $display("FAIL async_reset_outputs: got w=%h rvalid=%b want 0", bus.icon_w_o, bus.icon_rvalid_o); end
    n_tests++; if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL async_reset_fifo: got busy=%b ready=%b want 0 1", bus.busy_o, bus.req_ready_o); end
    tick(); reset_n = 1'b1; dir_wsucc = 1'b1;
    tick();
    wbase = wlog_addr.size(); ebase = n_err;
    sbase = strobes[0] + strobes[1] + strobes[2] + strobes[3];
    bus.req_valid_i = 1'b1; bus.req_addr_i = mk(5, 0, 0); // c0
    tick(); bus.req_valid_i = 1'b0; #3;                   // c1
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", bus.err_o); end
    tick(); #3;                                           // c2
    n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", bus.err_o); end
    tick(); #3;                                           // c3
    n_tests++; if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL err_after: got err=%b busy=%b want 0 0", bus.err_o, bus.busy_o); end
    repeat (15) tick();
    n_tests++; if (wlog_addr.size() !== wbase || n_err - ebase !== 1) begin n_fail++; $display("FAIL reset_discard: got writes=%0d errs=%0d want 0 1", wlog_addr.size() - wbase, n_err - ebase); end
    n_tests++; if (strobes[0] + strobes[1] + strobes[2] + strobes[3] !== sbase) begin n_fail++; $display("FAIL err_no_strobe: got %0d strobes want 0", strobes[0] + strobes[1] + strobes[2] + strobes[3] - sbase); end
    dir_mask = '0;
  endtask

  task automatic test_random();
    type_exec_unit_addr pending [$];
    type_exec_unit_addr a;
    int exp_err, ebase, dbase, wbase, nw, idx;
    bit drained;
    exp_err = 0; ebase = n_err; dbase = n_done; wbase = wlog_addr.size();
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = mk($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 1));
      end else begin
        bus.req_valid_i = 1'b0;
      end
      #3;
      if (bus.req_valid_i && bus.req_ready_o) begin
        if (32'(bus.req_addr_i.euidx) < NUM_EU) pending.push_back(bus.req_addr_i);
        else exp_err++;
      end
      tick();
    end
    bus.req_valid_i = 1'b0;
    drained = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      #3;
      if (bus.busy_o === 1'b0) begin drained = 1'b1; break; end
      tick();
    end
    tick(); tick();
    n_tests++; if (!drained) begin n_fail++; $display("FAIL rand_drain: got busy=%b want 0", bus.busy_o); end
    nw = wlog_addr.size() - wbase;
    for (int j = 0; j < nw; j++) begin
      a = wlog_addr[wbase+j];
      idx = -1;
      for (int p = 0; p < pending.size(); p++) if (pending[p] === a) begin idx = p; break; end
      n_tests++;
      if (idx < 0) begin n_fail++; $display("FAIL rand_unexpected_write: got addr %h want a pending request", a); end
      else pending.delete(idx);
      n_tests++; if (wlog_data[wbase+j] !== data_of(a)) begin n_fail++; $display("FAIL rand_data: got %h want %h", wlog_data[wbase+j], data_of(a)); end
    end
    n_tests++; if (pending.size() !== 0) begin n_fail++; $display("FAIL rand_lost: got %0d unforwarded want 0", pending.size()); end
    n_tests++; if (n_err - ebase !== exp_err) begin n_fail++; $display("FAIL rand_err: got %0d want %0d", n_err - ebase, exp_err); end
    n_tests++; if (n_done - dbase !== nw) begin n_fail++; $display("FAIL rand_done: got %0d want %0d", n_done - dbase, nw); end
    rand_mode = 1'b0;
    tick();
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    test_reset();
    test_basic();
    test_read_retry();
    test_rotate();
    test_fifo_full();
    test_write_backpressure();
    test_reset_mid_write_err();
    test_random();
    n_tests++; if (prot_viol !== 0) begin n_fail++; $display("FAIL protocol: got %0d violations want 0", prot_viol); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
